// File: rtl/piso_arb_pkg.sv
// Shared types and helpers for the round-robin PISO transmit arbiter.
package piso_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Scans from last_grant+1 upward, wrapping at n_req; supports up to 8 requesters.
  function automatic logic [2:0] rr_winner(input logic [7:0]  valid,
                                           input logic [2:0]  last_grant,
                                           input int unsigned n_req);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = last_grant;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k <= n_req) begin
        idx = (32'(last_grant) + k) % n_req;
        if (!found && valid[idx[2:0]]) begin
          win   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/piso_tx_arbiter_shifter.sv
// Parallel-in serial-out shift register, MSB first, zero fill; load beats shift.
module piso_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (reset)
      sreg <= '0;
    else if (load)
      sreg <= data_in;
    else if (shift_en)
      sreg <= {sreg[WIDTH-2:0], 1'b0};
  end

  assign serial_out = sreg[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin scheduler sharing one PISO shifter among N_REQ requesters.
// Optional trailing even-parity bit enabled by defining PISO_ARB_PARITY_EN.
module piso_tx_arbiter
  import piso_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     tx_en,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     frame_start,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int unsigned GW    = $clog2(N_REQ);
  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [GW-1:0]    last_grant, winner;
  logic [7:0]       valid8;
  logic [WIDTH-1:0] word;
  logic             accept, shift_en, sh_msb, bit_last;
`ifdef PISO_ARB_PARITY_EN
  logic             parity;
`endif

  always_comb begin
    valid8 = '0;
    valid8[N_REQ-1:0] = req_valid;
  end

  assign winner   = GW'(rr_winner(valid8, 3'(last_grant), N_REQ));
  assign word     = req_data[winner*WIDTH +: WIDTH];
  assign accept   = (state == IDLE) && !reset && (|req_valid);
  assign bit_last = (bit_cnt == CNT_W'(WIDTH-1));
  assign busy     = (state != IDLE);

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .shift_en   (shift_en),
    .data_in    (word),
    .serial_out (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(N_REQ-1);
`ifdef PISO_ARB_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant_id   <= winner;
        last_grant <= winner;
        bit_cnt    <= '0;
`ifdef PISO_ARB_PARITY_EN
        parity     <= ^word;
`endif
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (tx_en && bit_last)
`ifdef PISO_ARB_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = IDLE;
`endif
`ifdef PISO_ARB_PARITY_EN
      PARITY: if (tx_en) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    shift_en     = 1'b0;
    case (state)
      IDLE: if (accept) req_ready[winner] = 1'b1;
      SHIFT: begin
        serial_out = sh_msb;
        if (tx_en) begin
          serial_valid = 1'b1;
          shift_en     = 1'b1;
          frame_start  = (bit_cnt == '0);
        end
      end
`ifdef PISO_ARB_PARITY_EN
      PARITY: begin
        serial_out   = parity;
        serial_valid = tx_en;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter (N_REQ=4, WIDTH=8); follows PISO_ARB_PARITY_EN.
module tb_piso_tx_arbiter;

`ifdef PISO_ARB_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic        serial_out, serial_valid, frame_start, busy;
  logic [1:0]  grant_id;

  int vectors = 0;
  int errors  = 0;

  piso_tx_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_en        (tx_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return (i < 8) ? w[7-i] : ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the IDLE cycle with inputs already driven; returns in the following IDLE cycle.
  task automatic frame(input string tag, input logic [3:0] exp_ready, input logic [7:0] w,
                       input logic [1:0] gid, input logic [3:0] mid_valid, input bit drop);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, "_idle"},  32'(busy), 32'd0);
    tick();
    if (drop) req_valid = req_valid & ~exp_ready;
    for (int i = 0; i < NB; i++) begin
      if (i == 3) req_valid = req_valid | mid_valid;
      #1;
      check($sformatf("%s_sv%0d", tag, i), 32'(serial_valid), 32'd1);
      check($sformatf("%s_bit%0d", tag, i), 32'(serial_out), 32'(exp_bit(w, i)));
      check($sformatf("%s_fs%0d", tag, i), 32'(frame_start), 32'(i == 0));
      check($sformatf("%s_gid%0d", tag, i), 32'(grant_id), 32'(gid));
      check($sformatf("%s_nordy%0d", tag, i), 32'(req_ready), 32'd0);
      tick();
    end
    #1;
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_sv"},   32'(serial_valid), 32'd0);
  endtask

  initial begin
    int b;
    reset = 1'b1; req_valid = '0; req_data = '0; tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    #1;
    check("rst_ready_forced", 32'(req_ready), 32'd0);
    reset = 1'b0; req_valid = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sv",   32'(serial_valid), 32'd0);
    check("rst_so",   32'(serial_out), 32'd0);
    check("rst_gid",  32'(grant_id), 32'd0);
    check("rst_rdy",  32'(req_ready), 32'd0);
    tick();

    // all four valid and held: 0,1,2,3,0 with one IDLE cycle between frames
    req_data = 32'h4433_2211;
    req_valid = 4'b1111;
    frame("rr0", 4'b0001, 8'h11, 2'd0, 4'b0000, 1'b0);
    frame("rr1", 4'b0010, 8'h22, 2'd1, 4'b0000, 1'b0);
    frame("rr2", 4'b0100, 8'h33, 2'd2, 4'b0000, 1'b0);
    frame("rr3", 4'b1000, 8'h44, 2'd3, 4'b0000, 1'b0);
    frame("rr4", 4'b0001, 8'h11, 2'd0, 4'b0000, 1'b0);
    req_valid = '0;

    // single request, 0xA5 on requester 0
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    frame("a5", 4'b0001, 8'hA5, 2'd0, 4'b0000, 1'b1);

    // 0xF0 on requester 1 with a 3-cycle tx_en stall after the third bit
    req_data[15:8] = 8'hF0;
    req_valid = 4'b0010;
    #1;
    check("st_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    b = 0;
    for (int c = 1; c <= NB + 3; c++) begin
      tx_en = !(c >= 4 && c <= 6);
      #1;
      if (!tx_en) begin
        check($sformatf("st_stall_sv%0d", c), 32'(serial_valid), 32'd0);
        check($sformatf("st_stall_fs%0d", c), 32'(frame_start), 32'd0);
      end else begin
        check($sformatf("st_sv%0d", c), 32'(serial_valid), 32'd1);
        check($sformatf("st_bit%0d", b), 32'(serial_out), 32'(exp_bit(8'hF0, b)));
        b++;
      end
      tick();
    end
    tx_en = 1'b1;
    #1;
    check("st_end_busy", 32'(busy), 32'd0);

    // reset during bit 4 of 0xFF while requester 2 waits
    req_data[7:0]   = 8'hFF;
    req_data[23:16] = 8'h33;
    req_valid = 4'b0001;
    #1;
    check("rs_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rs_bit%0d", i), 32'(serial_out), 32'd1);
      check($sformatf("rs_nordy%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    reset = 1'b1;
    req_valid = 4'b0101;
    #1;
    check("rs_ready_forced", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_so",   32'(serial_out), 32'd0);
    check("rs_sv",   32'(serial_valid), 32'd0);
    check("rs_gid",  32'(grant_id), 32'd0);
    frame("rs_r0", 4'b0001, 8'hFF, 2'd0, 4'b0000, 1'b1);
    frame("rs_r2", 4'b0100, 8'h33, 2'd2, 4'b0000, 1'b1);

    // requester 3 arrives mid-frame and is taken at the next IDLE cycle
    req_data[7:0]   = 8'h5A;
    req_data[31:24] = 8'hC3;
    req_valid = 4'b0001;
    frame("mf0", 4'b0001, 8'h5A, 2'd0, 4'b1000, 1'b1);
    frame("mf3", 4'b1000, 8'hC3, 2'd3, 4'b0000, 1'b1);

    // parity words (trailing bit checked only when the parity build is enabled)
    req_data[7:0] = 8'h07;
    req_valid = 4'b0001;
    frame("p07", 4'b0001, 8'h07, 2'd0, 4'b0000, 1'b1);
    req_data[7:0] = 8'h03;
    req_valid = 4'b0001;
    frame("p03", 4'b0001, 8'h03, 2'd0, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Round-robin transmit scheduler that shares one parallel-in serial-out shifter between N_REQ requesters. Each requester offers a WIDTH-bit word over a valid/ready handshake. The block grants one requester, loads its word into the shifter and sequences WIDTH MSB-first shift cycles, with an optional parity bit. It sits between the parallel producers and the single serial line.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 8: bits per word, ≥2.
- clk  input  1: clock, all logic on posedge.
- reset  input  1: synchronous, active-high.
- req_valid  input  N_REQ: bit i high means requester i offers a word.
- req_data  input  N_REQ*WIDTH: word i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ: one-hot accept strobe; a word is taken when req_valid[i] && req_ready[i].
- tx_en  input  1: line enable; low stalls shifting.
- serial_out  output  1: serial data, MSB first.
- serial_valid  output  1: serial_out carries a frame bit this cycle.
- frame_start  output  1: high on the first bit of a frame.
- grant_id  output  $clog2(N_REQ): index of the requester being transmitted.
- busy  output  1: frame in progress (state ≠ IDLE).

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- IDLE: if any req_valid, pick the winner round-robin and assert req_ready[winner] combinationally in the same cycle. At the edge:
  - load the shifter with the word;
  - grant_id <= winner;
  - bit_cnt <= 0;
  - last_grant <= winner;
  - go to SHIFT.
- Round-robin: search starts at last_grant+1 and wraps modulo N_REQ. Reset sets last_grant = N_REQ-1, so requester 0 has first priority.
- SHIFT with tx_en=1: serial_valid=1 and serial_out=shifter MSB. At the edge, shift left with zero fill and increment bit_cnt.
  - When bit_cnt==WIDTH-1, go to PARITY if enabled, else IDLE.
- SHIFT with tx_en=0: serial_valid=0; shifter, bit_cnt and state hold.
- req_ready is all-zero outside IDLE. Requests arriving mid-frame wait; they are never dropped.
- Unselected req_valid lines are ignored; the requester keeps req_valid and req_data stable until ready.
- frame_start=1 only when bit_cnt==0, state is SHIFT and tx_en=1.
- Outputs in IDLE: serial_out=0, serial_valid=0, frame_start=0. grant_id holds its last value.

## Timing
- Handshake at cycle T. First bit at T+1; last data bit at T+WIDTH with no stalls. IDLE again at T+WIDTH+1, or T+WIDTH+2 with parity.
- One mandatory IDLE cycle between frames. The earliest next accept is the first IDLE cycle, and the next first bit follows one cycle later.
- Each stall cycle delays all subsequent bits by one cycle.
- reset=1 at any edge, including mid-frame: the frame is aborted. Next cycle has state=IDLE, shifter=0, bit_cnt=0, grant_id=0, last_grant=N_REQ-1, busy=0, serial_valid=0, serial_out=0 and req_ready=0. req_ready is also forced 0 during the reset cycle itself.

## Configuration
- PISO_ARB_PARITY_EN defined:
  - the parity register accumulates the XOR of the accepted word at load;
  - after the last data bit the PARITY state drives serial_out = even parity of the word, with serial_valid=1;
  - PARITY honours tx_en stalls like SHIFT;
  - frame length is WIDTH+1 valid bits.
- Undefined: no PARITY state and no parity register; frame length is WIDTH bits.

## Structure
- Package piso_arb_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - a function for the round-robin winner given req_valid and last_grant;
  - a CNT_W = $clog2(WIDTH) helper.
- Sub-module piso_shifter, parameter WIDTH:
  - ports clk, reset, load, shift_en, data_in, serial_out;
  - load has priority over shift_en;
  - shifts left with zero fill; serial_out is the MSB.
- The arbiter instantiates exactly one piso_shifter.

## Test plan
- Defaults, single request req_valid=0001, word 0xA5 -> req_ready=0001 for one cycle; serial_out 1,0,1,0,0,1,0,1 on 8 consecutive serial_valid cycles; frame_start on the first; grant_id=0.
- All four valid, words 0x11/0x22/0x33/0x44, held -> grant order 0,1,2,3,0; each frame 8 bits; exactly one IDLE cycle between frames.
- tx_en low for 3 cycles after bit 2 of 0xF0 -> serial_valid drops for exactly those 3 cycles; the bit sequence is still 1111_0000; frame ends 3 cycles later.
- reset pulsed at bit 4 of 0xFF, with requester 2 also pending -> next cycle busy=0, serial_out=0; then requester 0 wins over requester 2 when both are valid.
- With PISO_ARB_PARITY_EN, word 0x07 -> 9 valid bits, the 9th bit = 1; word 0x03 -> 9th bit = 0.
- Request arriving mid-frame on requester 3 -> req_ready[3] stays low until the IDLE cycle, then is accepted the cycle after the current frame ends.
